// File: rtl/insa_pkg.sv
// Shared types and constants for the INSA store-range buffer.
// Optional merge behaviour is controlled by the INSA_STORE_BUF_MERGE_EN macro.
package insa_pkg;

    // Default number of range entries and the native entry width.
    localparam int INSA_BUF_DEPTH = 16;
    localparam int INSA_AW        = 32;

    // Store size encoding on the commit interface.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // One recorded store: inclusive byte range [first, last].
    typedef struct packed {
        logic [INSA_AW-1:0] first;
        logic [INSA_AW-1:0] last;
    } insa_range_t;

endpackage

// File: rtl/insa_store_buf_if.sv
// Commit/ALU-side bus of the INSA store-range buffer.
// The master side (commit stage + ALU) drives stores, clears and read
// indices; the slave side (the buffer) returns the indexed range and status.
interface insa_store_buf_if #(
    parameter int AW    = 32,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          commit_valid_i;
    logic [AW-1:0] commit_addr_i;
    logic [1:0]    commit_size_i;
    logic          rst_buf_i;
    logic          en_crash_i;
    logic [19:0]   read_index_i;
    logic [AW-1:0] read_first_o;
    logic [AW-1:0] read_last_o;
    logic          data_in_buffer_o;
    logic [CW-1:0] count_o;
    logic          overflow_o;
    logic          crash_o;

    modport master (
        output commit_valid_i, commit_addr_i, commit_size_i,
        output rst_buf_i, en_crash_i, read_index_i,
        input  read_first_o, read_last_o, data_in_buffer_o,
        input  count_o, overflow_o, crash_o
    );

    modport slave (
        input  commit_valid_i, commit_addr_i, commit_size_i,
        input  rst_buf_i, en_crash_i, read_index_i,
        output read_first_o, read_last_o, data_in_buffer_o,
        output count_o, overflow_o, crash_o
    );

endinterface

// File: rtl/insa_range_ram.sv
// Flop array of store ranges: one synchronous write port, one
// asynchronous read port. Contents reset to zero.
module insa_range_ram
    import insa_pkg::*;
#(
    parameter int DEPTH = INSA_BUF_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  insa_range_t              i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output insa_range_t              o_rdata
);

    insa_range_t r_mem [DEPTH];

    // Entry storage: cleared on reset, one entry written per cycle.
    // NOTE: this array is deliberately reset so every entry reads as zero
    // after reset; storage that has no observable reset value would normally
    // drop the reset branch and save the reset fan-out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/insa_store_buf.sv
// Commit-side circular log of retired store byte ranges, oldest first,
// indexed combinationally by the ALU INSA read ops.
// Optional macro INSA_STORE_BUF_MERGE_EN: a store that starts right after
// the newest range extends that range instead of pushing a new entry.
// AW must not exceed insa_pkg::INSA_AW (entries are stored at that width).
module insa_store_buf
    import insa_pkg::*;
#(
    parameter int DEPTH = INSA_BUF_DEPTH,
    parameter int AW    = INSA_AW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    insa_store_buf_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_crash;

    logic          w_full;
    logic          w_do_commit;
    logic          w_merge;
    logic [AW-1:0] w_last_new;
    logic [PW-1:0] w_waddr;
    insa_range_t   w_wdata;
    logic [PW-1:0] w_rslot;
    logic          w_rvalid;
    insa_range_t   w_rdata;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_do_commit = bus.commit_valid_i && !bus.rst_buf_i;
    // Inclusive last byte; wraps mod 2^AW with no special casing.
    assign w_last_new  = bus.commit_addr_i
                       + ((AW'(1) << bus.commit_size_i) - AW'(1));

`ifdef INSA_STORE_BUF_MERGE_EN
    // Shadow of the newest entry so merging needs no second RAM read port.
    insa_range_t   r_newest;
    logic [AW-1:0] w_newest_last;

    assign w_newest_last = AW'(r_newest.last);
    assign w_merge = w_do_commit
                  && (r_count != '0)
                  && (bus.commit_addr_i == w_newest_last + AW'(1))
                  && (w_newest_last != {AW{1'b1}});

    // Track whatever was last written so it always mirrors the newest entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_newest <= '0;
        end else if (w_do_commit) begin
            r_newest <= w_wdata;
        end
    end
`else
    assign w_merge = 1'b0;
`endif

    // Build the entry to write: a fresh range, or the newest range extended.
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and infers a latch.
    always_comb begin
        w_wdata       = '0;
        w_waddr       = r_wr_ptr;
        w_wdata.first = INSA_AW'(bus.commit_addr_i);
        w_wdata.last  = INSA_AW'(w_last_new);
`ifdef INSA_STORE_BUF_MERGE_EN
        if (w_merge) begin
            w_waddr       = r_wr_ptr - PW'(1);
            w_wdata.first = r_newest.first;
        end
`endif
    end

    // Pointer, occupancy and sticky-flag update; clear beats commit.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_crash    <= 1'b0;
        end else if (bus.rst_buf_i) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_crash    <= 1'b0;
        end else if (bus.commit_valid_i && !w_merge) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_full) begin
                // Oldest entry is overwritten: advance the read side too.
                r_rd_ptr   <= r_rd_ptr + PW'(1);
                r_overflow <= 1'b1;
                if (bus.en_crash_i) begin
                    r_crash <= 1'b1;
                end
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    insa_range_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_we    (w_do_commit),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_rslot),
        .o_rdata (w_rdata)
    );

    // Logical index 0 is the oldest entry; indices past count read as zero.
    assign w_rslot  = r_rd_ptr + bus.read_index_i[PW-1:0];
    assign w_rvalid = (32'(bus.read_index_i) < 32'(r_count));

    assign bus.read_first_o     = w_rvalid ? AW'(w_rdata.first) : '0;
    assign bus.read_last_o      = w_rvalid ? AW'(w_rdata.last)  : '0;
    assign bus.data_in_buffer_o = (r_count != '0);
    assign bus.count_o          = r_count;
    assign bus.overflow_o       = r_overflow;
    assign bus.crash_o          = r_crash;

endmodule

// File: tb/tb_insa_store_buf.sv
// Directed self-checking bench for insa_store_buf (DEPTH=16, AW=32).
// Expectations follow INSA_STORE_BUF_MERGE_EN when that macro is defined.
module tb_insa_store_buf;
    import insa_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 32;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   n_checks = 0;
    int   n_fail   = 0;

    insa_store_buf_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

    insa_store_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; return 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_commit(input logic [31:0] addr, input logic [1:0] size);
        bus.commit_valid_i = 1'b1;
        bus.commit_addr_i  = addr;
        bus.commit_size_i  = size;
        tick();
        bus.commit_valid_i = 1'b0;
    endtask

    task automatic clear_buf();
        bus.rst_buf_i = 1'b1;
        tick();
        bus.rst_buf_i = 1'b0;
    endtask

    task automatic set_index(input logic [19:0] idx);
        bus.read_index_i = idx;
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #2;
        set_index(20'd0);
        n_checks++; if (bus.read_first_o !== 32'h0) begin n_fail++;
            $display("FAIL reset_first: got 0x%h expected 0x0", bus.read_first_o); end
        n_checks++; if (bus.read_last_o !== 32'h0) begin n_fail++;
            $display("FAIL reset_last: got 0x%h expected 0x0", bus.read_last_o); end
        n_checks++; if (bus.data_in_buffer_o !== 1'b0) begin n_fail++;
            $display("FAIL reset_dib: got %b expected 0", bus.data_in_buffer_o); end
        n_checks++; if (bus.count_o !== 5'd0) begin n_fail++;
            $display("FAIL reset_count: got %0d expected 0", bus.count_o); end
        n_checks++; if (bus.overflow_o !== 1'b0) begin n_fail++;
            $display("FAIL reset_overflow: got %b expected 0", bus.overflow_o); end
        n_checks++; if (bus.crash_o !== 1'b0) begin n_fail++;
            $display("FAIL reset_crash: got %b expected 0", bus.crash_o); end
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single_commit();
        bus.commit_valid_i = 1'b1;
        bus.commit_addr_i  = 32'h1000;
        bus.commit_size_i  = SZ_W;
        set_index(20'd0);
        n_checks++; if (bus.count_o !== 5'd0) begin n_fail++;
            $display("FAIL same_cycle_count: got %0d expected 0", bus.count_o); end
        tick();
        bus.commit_valid_i = 1'b0;
        set_index(20'd0);
        n_checks++; if (bus.read_first_o !== 32'h1000) begin n_fail++;
            $display("FAIL single_first: got 0x%h expected 0x1000", bus.read_first_o); end
        n_checks++; if (bus.read_last_o !== 32'h1003) begin n_fail++;
            $display("FAIL single_last: got 0x%h expected 0x1003", bus.read_last_o); end
        n_checks++; if (bus.count_o !== 5'd1) begin n_fail++;
            $display("FAIL single_count: got %0d expected 1", bus.count_o); end
        n_checks++; if (bus.data_in_buffer_o !== 1'b1) begin n_fail++;
            $display("FAIL single_dib: got %b expected 1", bus.data_in_buffer_o); end
    endtask

    task automatic test_merge();
        clear_buf();
        do_commit(32'h2000, SZ_W);
        do_commit(32'h2004, SZ_W);
`ifdef INSA_STORE_BUF_MERGE_EN
        set_index(20'd0);
        n_checks++; if (bus.count_o !== 5'd1) begin n_fail++;
            $display("FAIL merge_count: got %0d expected 1", bus.count_o); end
        n_checks++; if (bus.read_first_o !== 32'h2000) begin n_fail++;
            $display("FAIL merge_first: got 0x%h expected 0x2000", bus.read_first_o); end
        n_checks++; if (bus.read_last_o !== 32'h2007) begin n_fail++;
            $display("FAIL merge_last: got 0x%h expected 0x2007", bus.read_last_o); end
        set_index(20'd1);
        n_checks++; if (bus.read_first_o !== 32'h0) begin n_fail++;
            $display("FAIL merge_idx1: got 0x%h expected 0x0", bus.read_first_o); end
`else
        set_index(20'd0);
        n_checks++; if (bus.count_o !== 5'd2) begin n_fail++;
            $display("FAIL nomerge_count: got %0d expected 2", bus.count_o); end
        n_checks++; if (bus.read_last_o !== 32'h2003) begin n_fail++;
            $display("FAIL nomerge_idx0_last: got 0x%h expected 0x2003", bus.read_last_o); end
        set_index(20'd1);
        n_checks++; if (bus.read_first_o !== 32'h2004) begin n_fail++;
            $display("FAIL nomerge_idx1_first: got 0x%h expected 0x2004", bus.read_first_o); end
        n_checks++; if (bus.read_last_o !== 32'h2007) begin n_fail++;
            $display("FAIL nomerge_idx1_last: got 0x%h expected 0x2007", bus.read_last_o); end
`endif
    endtask

    // Sizes, address wrap, and no-merge across the top of the address space.
    task automatic test_sizes_wrap();
        clear_buf();
        do_commit(32'h3000, SZ_D);
        do_commit(32'h5001, SZ_H);
        do_commit(32'hFFFF_FFFE, SZ_W);
        do_commit(32'hFFFF_FFFF, SZ_B);
        do_commit(32'h0000_0000, SZ_B);
        set_index(20'd0);
        n_checks++; if (bus.read_last_o !== 32'h3007) begin n_fail++;
            $display("FAIL dword_last: got 0x%h expected 0x3007", bus.read_last_o); end
        set_index(20'd1);
        n_checks++; if (bus.read_last_o !== 32'h5002) begin n_fail++;
            $display("FAIL half_last: got 0x%h expected 0x5002", bus.read_last_o); end
        set_index(20'd2);
        n_checks++; if (bus.read_first_o !== 32'hFFFF_FFFE || bus.read_last_o !== 32'h1) begin n_fail++;
            $display("FAIL wrap_range: got 0x%h..0x%h expected 0xfffffffe..0x1",
                     bus.read_first_o, bus.read_last_o); end
        tick();
        set_index(20'd4);
        n_checks++; if (bus.read_first_o !== 32'h0 || bus.count_o !== 5'd5) begin n_fail++;
            $display("FAIL wrap_nomerge: got first 0x%h count %0d expected 0x0 count 5",
                     bus.read_first_o, bus.count_o); end
    endtask

    // Clear and commit together at count=5: commit is dropped.
    task automatic test_rst_buf_concurrent();
        bus.rst_buf_i      = 1'b1;
        bus.commit_valid_i = 1'b1;
        bus.commit_addr_i  = 32'h7000;
        bus.commit_size_i  = SZ_W;
        tick();
        bus.rst_buf_i      = 1'b0;
        bus.commit_valid_i = 1'b0;
        tick();
        set_index(20'd0);
        n_checks++; if (bus.count_o !== 5'd0) begin n_fail++;
            $display("FAIL clr5_count: got %0d expected 0", bus.count_o); end
        n_checks++; if (bus.read_first_o !== 32'h0 || bus.read_last_o !== 32'h0) begin n_fail++;
            $display("FAIL clr5_read: got 0x%h..0x%h expected 0x0..0x0",
                     bus.read_first_o, bus.read_last_o); end
        n_checks++; if (bus.data_in_buffer_o !== 1'b0) begin n_fail++;
            $display("FAIL clr5_dib: got %b expected 0", bus.data_in_buffer_o); end
    endtask

    task automatic test_overflow();
        clear_buf();
        // Overwrite without crash arming: overflow only.
        for (int k = 0; k <= 16; k++) do_commit(32'h100 * k, SZ_B);
        n_checks++; if (bus.overflow_o !== 1'b1 || bus.crash_o !== 1'b0) begin n_fail++;
            $display("FAIL ovf_unarmed: got ovf %b crash %b expected 1 0",
                     bus.overflow_o, bus.crash_o); end
        clear_buf();
        bus.en_crash_i = 1'b1;
        for (int k = 0; k < 16; k++) do_commit(32'h100 * k, SZ_B);
        set_index(20'd0);
        n_checks++; if (bus.count_o !== 5'd16 || bus.overflow_o !== 1'b0 || bus.crash_o !== 1'b0) begin n_fail++;
            $display("FAIL full_no_ovf: got count %0d ovf %b crash %b expected 16 0 0",
                     bus.count_o, bus.overflow_o, bus.crash_o); end
        do_commit(32'h1000, SZ_B);
        bus.en_crash_i = 1'b0;
        set_index(20'd0);
        n_checks++; if (bus.count_o !== 5'd16) begin n_fail++;
            $display("FAIL ovf_count: got %0d expected 16", bus.count_o); end
        n_checks++; if (bus.read_first_o !== 32'h100) begin n_fail++;
            $display("FAIL ovf_idx0: got 0x%h expected 0x100", bus.read_first_o); end
        n_checks++; if (bus.overflow_o !== 1'b1 || bus.crash_o !== 1'b1) begin n_fail++;
            $display("FAIL ovf_flags: got ovf %b crash %b expected 1 1",
                     bus.overflow_o, bus.crash_o); end
        set_index(20'd15);
        n_checks++; if (bus.read_first_o !== 32'h1000 || bus.read_last_o !== 32'h1000) begin n_fail++;
            $display("FAIL ovf_idx15: got 0x%h..0x%h expected 0x1000..0x1000",
                     bus.read_first_o, bus.read_last_o); end
        set_index(20'd16);
        n_checks++; if (bus.read_first_o !== 32'h0) begin n_fail++;
            $display("FAIL ovf_idx16: got 0x%h expected 0x0", bus.read_first_o); end
        // Disarmed overwrite: crash stays sticky, log keeps sliding.
        do_commit(32'h1100, SZ_B);
        set_index(20'd0);
        n_checks++; if (bus.crash_o !== 1'b1 || bus.read_first_o !== 32'h200) begin n_fail++;
            $display("FAIL sticky_slide: got crash %b idx0 0x%h expected 1 0x200",
                     bus.crash_o, bus.read_first_o); end
        set_index(20'd15);
        n_checks++; if (bus.read_first_o !== 32'h1100) begin n_fail++;
            $display("FAIL slide_idx15: got 0x%h expected 0x1100", bus.read_first_o); end
        // Clear with a concurrent commit while flags are set.
        bus.rst_buf_i      = 1'b1;
        bus.commit_valid_i = 1'b1;
        bus.commit_addr_i  = 32'h9000;
        tick();
        bus.rst_buf_i      = 1'b0;
        bus.commit_valid_i = 1'b0;
        set_index(20'd0);
        n_checks++; if (bus.count_o !== 5'd0 || bus.overflow_o !== 1'b0 || bus.crash_o !== 1'b0) begin n_fail++;
            $display("FAIL clr_full: got count %0d ovf %b crash %b expected 0 0 0",
                     bus.count_o, bus.overflow_o, bus.crash_o); end
        n_checks++; if (bus.read_first_o !== 32'h0) begin n_fail++;
            $display("FAIL clr_full_read: got 0x%h expected 0x0", bus.read_first_o); end
    endtask

    task automatic test_read_oob();
        clear_buf();
        do_commit(32'hA000, SZ_B);
        do_commit(32'hB000, SZ_B);
        do_commit(32'hC000, SZ_B);
        set_index(20'd2);
        n_checks++; if (bus.read_first_o !== 32'hC000) begin n_fail++;
            $display("FAIL oob_idx2: got 0x%h expected 0xc000", bus.read_first_o); end
        set_index(20'd3);
        n_checks++; if (bus.read_first_o !== 32'h0) begin n_fail++;
            $display("FAIL oob_idx3: got 0x%h expected 0x0", bus.read_first_o); end
        tick();
        set_index(20'd20);
        n_checks++; if (bus.read_first_o !== 32'h0 || bus.read_last_o !== 32'h0) begin n_fail++;
            $display("FAIL oob_idx20: got 0x%h..0x%h expected 0x0..0x0",
                     bus.read_first_o, bus.read_last_o); end
        set_index(20'h10001);
        n_checks++; if (bus.read_first_o !== 32'h0) begin n_fail++;
            $display("FAIL oob_high: got 0x%h expected 0x0", bus.read_first_o); end
    endtask

    task automatic test_async_reset();
        clear_buf();
        for (int k = 0; k < 7; k++) do_commit(32'hD000 + 32'h10 * k, SZ_B);
        set_index(20'd0);
        n_checks++; if (bus.count_o !== 5'd7) begin n_fail++;
            $display("FAIL pre_reset_count: got %0d expected 7", bus.count_o); end
        #1;
        rst_ni = 1'b0;
        #1;
        n_checks++; if (bus.count_o !== 5'd0 || bus.data_in_buffer_o !== 1'b0) begin n_fail++;
            $display("FAIL async_count: got count %0d dib %b expected 0 0",
                     bus.count_o, bus.data_in_buffer_o); end
        n_checks++; if (bus.read_first_o !== 32'h0 || bus.read_last_o !== 32'h0) begin n_fail++;
            $display("FAIL async_read: got 0x%h..0x%h expected 0x0..0x0",
                     bus.read_first_o, bus.read_last_o); end
        n_checks++; if (bus.overflow_o !== 1'b0 || bus.crash_o !== 1'b0) begin n_fail++;
            $display("FAIL async_flags: got ovf %b crash %b expected 0 0",
                     bus.overflow_o, bus.crash_o); end
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.commit_valid_i = 1'b0;
        bus.commit_addr_i  = '0;
        bus.commit_size_i  = SZ_B;
        bus.rst_buf_i      = 1'b0;
        bus.en_crash_i     = 1'b0;
        bus.read_index_i   = '0;
        test_reset();
        test_single_commit();
        test_merge();
        test_sizes_wrap();
        test_rst_buf_concurrent();
        test_overflow();
        test_read_oob();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
